// File: rtl/rt_schedule_monitor.sv
// Run-time observer for the grid-planning plant's scheduler. It checks that slots are
// exclusive, that the robot is not starved and that obstacle runs stay bounded.
// The first violation is latched as a sticky verdict with its code and armed-cycle index.
module rt_schedule_monitor #(
  parameter int unsigned MAX_GAP     = 4,
  parameter int unsigned MAX_OBS_RUN = 2,
  parameter int unsigned GAP_W       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       end_init,
  input  logic       rt_robot,
  input  logic       rt_obs1,
  input  logic       rt_obs2,
  input  logic       plant_error,
  output logic       armed,
  output logic       error,
  output logic [2:0] fail_code,
  output logic [7:0] fail_cycle,
  output logic [7:0] robot_slots
);

  localparam int unsigned RUN_W = (MAX_OBS_RUN < 1) ? 1 : $clog2(MAX_OBS_RUN + 1);
  localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(MAX_GAP);
  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(MAX_OBS_RUN);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_FAIL} state_e;
  typedef enum logic [1:0] {OBS_NONE, OBS_1, OBS_2} obs_e;
  typedef enum logic [2:0] {
    FC_NONE   = 3'd0,
    FC_PLANT  = 3'd1,
    FC_MULTI  = 3'd2,
    FC_STARVE = 3'd3,
    FC_RUN    = 3'd4
  } code_e;

  state_e           r_state, w_next;
  obs_e             r_last_obs;
  logic [GAP_W-1:0] r_gap;
  logic [RUN_W-1:0] r_run;
  logic [7:0]       r_cyc;
  logic             r_error;
  code_e            r_code;
  logic [7:0]       r_fail_cycle;
  logic [7:0]       r_robot_slots;

  logic  w_multi, w_one_obs, w_same_obs, w_viol;
  obs_e  w_obs_id;
  code_e w_code;

  assign w_multi    = (rt_robot & rt_obs1) | (rt_robot & rt_obs2) | (rt_obs1 & rt_obs2);
  assign w_one_obs  = rt_obs1 ^ rt_obs2;
  assign w_obs_id   = rt_obs1 ? OBS_1 : OBS_2;
  assign w_same_obs = w_one_obs && (w_obs_id == r_last_obs);

  // Evaluated in priority order so that only the highest-ranked code is latched.
  always_comb begin
    w_code = FC_NONE;
    if (plant_error)
      w_code = FC_PLANT;
    else if (w_multi)
      w_code = FC_MULTI;
    else if (!rt_robot && (r_gap == GAP_LIM))
      w_code = FC_STARVE;
    else if (w_same_obs && (r_run == RUN_LIM))
      w_code = FC_RUN;
  end

  assign w_viol = (w_code != FC_NONE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (end_init) w_next = S_ARMED;
      S_ARMED: if (w_viol)   w_next = S_FAIL;
      S_FAIL:  w_next = S_FAIL;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    armed = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gap         <= '0;
      r_run         <= '0;
      r_last_obs    <= OBS_NONE;
      r_cyc         <= '0;
      r_error       <= 1'b0;
      r_code        <= FC_NONE;
      r_fail_cycle  <= '0;
      r_robot_slots <= '0;
    end else if (r_state == S_ARMED) begin
      if (w_viol) begin
        r_error      <= 1'b1;
        r_code       <= w_code;
        r_fail_cycle <= r_cyc;
      end else begin
        r_gap <= rt_robot ? '0 : r_gap + 1'b1;
        if (rt_robot && (r_robot_slots != 8'hFF))
          r_robot_slots <= r_robot_slots + 8'd1;
        if (w_one_obs) begin
          r_run      <= w_same_obs ? r_run + 1'b1 : RUN_W'(1);
          r_last_obs <= w_obs_id;
        end else begin
          r_run      <= '0;
          r_last_obs <= OBS_NONE;
        end
        if (r_cyc != 8'hFF)
          r_cyc <= r_cyc + 8'd1;
      end
    end
  end

  assign error       = r_error;
  assign fail_code   = r_code;
  assign fail_cycle  = r_fail_cycle;
  assign robot_slots = r_robot_slots;

endmodule

// File: tb/tb_rt_schedule_monitor.sv
// Directed bench for rt_schedule_monitor: reset, idle masking, clean scheduling,
// each violation class, priority, freeze in FAIL, reset recovery and counter saturation.
module tb_rt_schedule_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       end_init = 1'b0;
  logic       rt_robot = 1'b0;
  logic       rt_obs1 = 1'b0;
  logic       rt_obs2 = 1'b0;
  logic       plant_error = 1'b0;
  logic       armed;
  logic       error;
  logic [2:0] fail_code;
  logic [7:0] fail_cycle;
  logic [7:0] robot_slots;

  int vectors = 0;
  int miscompares = 0;

  rt_schedule_monitor #(.MAX_GAP(4), .MAX_OBS_RUN(2), .GAP_W(3)) dut (
    .clk(clk), .rst(rst), .end_init(end_init),
    .rt_robot(rt_robot), .rt_obs1(rt_obs1), .rt_obs2(rt_obs2),
    .plant_error(plant_error),
    .armed(armed), .error(error), .fail_code(fail_code),
    .fail_cycle(fail_cycle), .robot_slots(robot_slots)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic r, input logic o1, input logic o2,
                      input logic pe, input logic ei);
    rt_robot = r; rt_obs1 = o1; rt_obs2 = o2; plant_error = pe; end_init = ei;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic a, input logic e,
                         input logic [2:0] code, input logic [7:0] cyc,
                         input logic [7:0] slots);
    chk({tag, ".armed"},       {7'd0, armed},     {7'd0, a});
    chk({tag, ".error"},       {7'd0, error},     {7'd0, e});
    chk({tag, ".fail_code"},   {5'd0, fail_code}, {5'd0, code});
    chk({tag, ".fail_cycle"},  fail_cycle,        cyc);
    chk({tag, ".robot_slots"}, robot_slots,       slots);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic arm(input logic pe);
    step(0, 0, 0, pe, 1);
  endtask

  initial begin
    // Reset and idle masking
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0);
    chk_all("reset", 0, 0, 3'd0, 8'd0, 8'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      logic [3:0] v;
      v = 4'(i + 5);
      step(v[0], v[1], v[2], v[3], 0);
    end
    chk_all("idle", 0, 0, 3'd0, 8'd0, 8'd0);

    // Clean round-robin: 30 cycles, 10 robot slots
    arm(0);
    chk({"arm", ".armed"}, {7'd0, armed}, 8'd1);
    for (int i = 0; i < 30; i++) begin
      case (i % 3)
        0:       step(1, 0, 0, 0, 0);
        1:       step(0, 1, 0, 0, 0);
        default: step(0, 0, 1, 0, 0);
      endcase
    end
    chk_all("rr", 1, 0, 3'd0, 8'd0, 8'd10);

    // MULTI at armed cycle 3, then frozen
    do_reset();
    arm(0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk({"multi_pre", ".error"}, {7'd0, error}, 8'd0);
    step(1, 0, 1, 0, 0);
    chk_all("multi", 1, 1, 3'd2, 8'd3, 8'd1);
    step(1, 0, 0, 1, 1);
    step(0, 1, 1, 0, 1);
    step(1, 0, 0, 0, 0);
    chk_all("multi_frozen", 1, 1, 3'd2, 8'd3, 8'd1);

    // Reset out of FAIL, then re-arm with a clean sequence
    do_reset();
    chk_all("rst_fail", 0, 0, 3'd0, 8'd0, 8'd0);
    arm(0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk_all("rearm", 1, 0, 3'd0, 8'd0, 8'd2);

    // STARVE: fifth robot-less cycle (armed cycle 5) flags
    do_reset();
    arm(0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk({"starve_pre", ".error"}, {7'd0, error}, 8'd0);
    step(0, 0, 1, 0, 0);
    chk_all("starve", 1, 1, 3'd3, 8'd5, 8'd1);

    // RUN: third consecutive obs1 slot flags
    do_reset();
    arm(0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk({"run_pre", ".error"}, {7'd0, error}, 8'd0);
    step(0, 1, 0, 0, 0);
    chk_all("run", 1, 1, 3'd4, 8'd2, 8'd0);

    // PLANT outranks MULTI; plant_error in the arming cycle is not checked
    do_reset();
    arm(1);
    chk({"plant_arm", ".error"}, {7'd0, error}, 8'd0);
    step(0, 1, 1, 1, 0);
    chk_all("plant", 1, 1, 3'd1, 8'd0, 8'd0);

    // Saturation of robot_slots and cyc
    do_reset();
    arm(0);
    for (int i = 0; i < 300; i++) step(1, 0, 0, 0, 0);
    chk({"sat_pre", ".robot_slots"}, robot_slots, 8'd255);
    chk({"sat_pre", ".error"}, {7'd0, error}, 8'd0);
    step(1, 1, 0, 0, 0);
    chk_all("sat", 1, 1, 3'd2, 8'd255, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rt_schedule_monitor.md
Name: rt_schedule_monitor

Overview:
- Observer stage directly downstream of the grid-planning plant.
- Consumes the plant's per-cycle real-time scheduling labels (robot, obstacle 1, obstacle 2) and its error flag.
- Checks that the scheduler driving the plant is exclusive, fair to the robot and bounded for obstacles.
- Latches a sticky verdict with a violation code and cycle index, used as the synthesis/model-checking objective.

Parameters:
- MAX_GAP, 4: maximum number of consecutive armed cycles allowed without a robot slot.
- MAX_OBS_RUN, 2: maximum consecutive slots granted to the same obstacle.
- GAP_W, 3: width of the gap counter. Must satisfy 2^GAP_W > MAX_GAP.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- end_init  input  1  plant initialisation phase over; arms the monitor.
- rt_robot  input  1  robot scheduled this cycle (plant _rt_robot).
- rt_obs1  input  1  obstacle 1 scheduled this cycle (plant _rt_obs1).
- rt_obs2  input  1  obstacle 2 scheduled this cycle (plant _rt_obs2).
- plant_error  input  1  plant collision error flag.
- armed  output  1  monitor in ARMED or FAIL state.
- error  output  1  sticky violation verdict.
- fail_code  output  3  0 none, 1 PLANT, 2 MULTI, 3 STARVE, 4 RUN.
- fail_cycle  output  8  armed-cycle index (0-based) of the first violation.
- robot_slots  output  8  saturating count of armed cycles with rt_robot=1.

Behaviour:
- Reset (rst=1 at the edge):
  - state=IDLE.
  - armed=0, error=0, fail_code=0, fail_cycle=0, robot_slots=0.
  - gap=0, run=0, last_obs=NONE, cyc=0.
  - Reset takes priority over every other event, including in FAIL and mid-run.
- FSM states: IDLE, ARMED, FAIL.
  - IDLE: no checks; all inputs except end_init ignored. end_init=1 → ARMED next cycle. The first checked cycle is the one after end_init is sampled.
  - ARMED: every cycle is evaluated combinationally on the inputs and current registers.
    - Any violation → FAIL at the edge.
    - Otherwise stay in ARMED. cyc increments, saturating at 255.
  - FAIL: terminal until rst. Inputs ignored and all outputs frozen. end_init ignored in ARMED and FAIL.
- Violation conditions (ARMED only):
  - PLANT: plant_error=1.
  - MULTI: rt_robot + rt_obs1 + rt_obs2 >= 2.
  - STARVE: rt_robot=0 and gap==MAX_GAP. The (MAX_GAP+1)th consecutive robot-less cycle flags.
  - RUN: exactly one obstacle label is high, it equals last_obs, and run==MAX_OBS_RUN.
- Priority when several conditions hold in one cycle: PLANT > MULTI > STARVE > RUN. Only the highest-priority code is latched.
- Register updates in ARMED when there is no violation:
  - gap: 0 if rt_robot, else gap+1.
  - robot_slots: +1 if rt_robot, saturating at 255.
  - Exactly one obstacle label high: run = (same as last_obs) ? run+1 : 1; last_obs = that obstacle.
  - Otherwise (robot slot or idle cycle): run=0, last_obs=NONE.
- On violation (registered outputs, 1-cycle latency):
  - The edge ending violating cycle t sets error=1, fail_code=code, fail_cycle=cyc(t).
  - error is observed high from cycle t+1.
  - robot_slots and gap are not updated on the violating edge.
- armed=1 from the cycle after end_init is sampled, through FAIL.
- cyc saturation: after 255 armed cycles, fail_cycle reports 255 for any later violation.

Test Plan:
- Reset and idle: rst for 2 cycles, then all rt_* toggling with end_init=0 for 10 cycles → armed=0, error=0, fail_code=0, robot_slots=0.
- Clean round-robin: end_init pulse, then robot, obs1, obs2 repeating for 30 cycles → error=0, robot_slots=10, armed=1.
- MULTI: armed; armed cycle 3 has rt_robot=1 and rt_obs2=1 → cycle after: error=1, fail_code=2, fail_cycle=3. Later inputs do not change outputs.
- STARVE: armed; robot at cycle 0, then obs1, obs2, idle, obs1, obs2 → violation in cycle 5 (gap=4). Next cycle: error=1, fail_code=3, fail_cycle=5.
- RUN, and PLANT priority:
  - Armed; obs1 in cycles 0, 1, 2 → fail_code=4, fail_cycle=2.
  - Separate run: cycle 0 has plant_error=1 and rt_obs1=rt_obs2=1 → fail_code=1.
- Reset mid-FAIL: force a MULTI failure, then rst=1 for one cycle → all outputs 0 and state IDLE. A new end_init re-arms, and a clean sequence keeps error=0.
